// File: rtl/ucsbece154a_fetch_pkg.sv
// rtl/ucsbece154a_fetch_pkg.sv - shared types and constants for the fetch stage
//
// Purpose: fetch-FSM state encoding, the reset instruction word, and the
// opcode/funct3 constants shared with the decoder.
package ucsbece154a_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LW     = 7'b000_0011;
  localparam logic [6:0] OP_SW     = 7'b010_0011;
  localparam logic [6:0] OP_RTYPE  = 7'b011_0011;
  localparam logic [6:0] OP_ITYPE  = 7'b001_0011;
  localparam logic [6:0] OP_BEQ    = 7'b110_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/ucsbece154a_pc_next.sv
// rtl/ucsbece154a_pc_next.sv - next-PC selection and target alignment check
//
// Purpose: combinational next-PC logic for the fetch stage.
// Ports:
//   pc        in  32  address of the held instruction
//   pc_src    in   1  1 selects pc_target, 0 selects pc + 4
//   pc_target in  32  branch/jump target
//   pc_plus4  out 32  pc + 4 (wraps modulo 2^32)
//   pc_next   out 32  selected next PC
//   misalign  out  1  a taken target is not word aligned
module ucsbece154a_pc_next
  import ucsbece154a_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_next,
  output logic        misalign
);

  assign pc_plus4 = pc + 32'd4;
  assign pc_next  = pc_src ? pc_target : pc_plus4;
  // pc_plus4 is always aligned because pc is, so only a taken target can misalign
  assign misalign = pc_src && (pc_target[1:0] != 2'b00);

endmodule

// File: rtl/ucsbece154a_fetch.sv
// rtl/ucsbece154a_fetch.sv - instruction fetch stage feeding the decoder
//
// Purpose: owns the PC, fetches one word per instruction over a req/ack
// handshake, holds it for the decoder, and advances the PC on done_i.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   imem_req_o/addr_o     read request and address (address = PC_o)
//   imem_rdata_i/ack_i    read data, captured on ack while requesting
//   done_i                datapath finished the held instruction
//   PCSrc_i, PCTarget_i   next-PC select and taken target
//   instr_valid_o         Instr_o and its fields are valid
//   Instr_o, op_o, funct3_o, funct7b5_o  held instruction and decoder fields
//   PC_o, PCPlus4_o       held instruction address and its successor
//   misalign_o            sticky: a taken target was misaligned (stage halted)
//   retire_cnt_o          completed-instruction count
module ucsbece154a_fetch
  import ucsbece154a_fetch_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE = 32'h0001_0000,
  parameter int          RETIRE_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req_o,
  output logic [31:0]         imem_addr_o,
  input  logic [31:0]         imem_rdata_i,
  input  logic                imem_ack_i,
  input  logic                done_i,
  input  logic                PCSrc_i,
  input  logic [31:0]         PCTarget_i,
  output logic                instr_valid_o,
  output logic [31:0]         Instr_o,
  output logic [6:0]          op_o,
  output logic [2:0]          funct3_o,
  output logic                funct7b5_o,
  output logic [31:0]         PC_o,
  output logic [31:0]         PCPlus4_o,
  output logic                misalign_o,
  output logic [RETIRE_W-1:0] retire_cnt_o
);

  fetch_state_t state;
  logic [31:0]  pc_next;
  logic         target_misalign;

  ucsbece154a_pc_next u_pc_next (
    .pc        (PC_o),
    .pc_src    (PCSrc_i),
    .pc_target (PCTarget_i),
    .pc_plus4  (PCPlus4_o),
    .pc_next   (pc_next),
    .misalign  (target_misalign)
  );

  // Request is a pure decode of the state register, so it is glitch-free
  // and drops the cycle after the ack is taken.
  assign imem_req_o  = (state == FETCH);
  assign imem_addr_o = PC_o;

  assign op_o       = Instr_o[6:0];
  assign funct3_o   = Instr_o[14:12];
  assign funct7b5_o = Instr_o[30];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      PC_o          <= TEXT_BASE;
      Instr_o       <= NOP_INSTR;
      instr_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      retire_cnt_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (imem_ack_i) begin
            Instr_o       <= imem_rdata_i;
            instr_valid_o <= 1'b1;
            state         <= EXEC;
          end
        end
        EXEC: begin
          if (done_i) begin
            retire_cnt_o  <= retire_cnt_o + RETIRE_W'(1);
            instr_valid_o <= 1'b0;
            if (target_misalign) begin
              // Keep PC_o pointing at the offending branch for debug.
              misalign_o <= 1'b1;
              state      <= HALT;
            end else begin
              PC_o  <= pc_next;
              state <= FETCH;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ucsbece154a_fetch.md
Name: ucsbece154a_fetch

Overview:
Instruction fetch stage directly upstream of the main/ALU decoder.
- Owns the PC register and issues word reads to instruction memory through a req/ack handshake.
- Holds the fetched instruction stable and presents op, funct3 and funct7b5 to the decoder.
- Consumes the decoder's PCSrc together with the datapath's branch/jump target to select the next PC when the downstream datapath signals completion.

Parameters:
TEXT_BASE, 32'h0001_0000, PC value loaded on reset (must be word aligned)
RETIRE_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req_o  output  1  instruction-memory read request
imem_addr_o  output  32  read address (equals PC_o)
imem_rdata_i  input  32  read data, valid when imem_ack_i=1
imem_ack_i  input  1  read complete; sampled only while imem_req_o=1
done_i  input  1  datapath has finished executing the held instruction
PCSrc_i  input  1  from decoder: 1 selects PCTarget_i, 0 selects PCPlus4_o
PCTarget_i  input  32  branch/jump target from datapath adder
instr_valid_o  output  1  Instr_o and derived fields are valid
Instr_o  output  32  held instruction word
op_o  output  7  Instr_o[6:0]
funct3_o  output  3  Instr_o[14:12]
funct7b5_o  output  1  Instr_o[30]
PC_o  output  32  address of the held instruction
PCPlus4_o  output  32  PC_o + 4
misalign_o  output  1  sticky: taken target had bits [1:0] != 0
retire_cnt_o  output  RETIRE_W  count of completed instructions

Behaviour:
- Reset values: state=IDLE, PC_o=TEXT_BASE, Instr_o=32'h0000_0013 (nop), instr_valid_o=0, imem_req_o=0, misalign_o=0, retire_cnt_o=0.
- Reset applies mid-operation: any outstanding request is abandoned, and an ack arriving after reset is ignored unless the FSM is in FETCH.
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE -> FETCH unconditionally on the next clock. This gives one bubble cycle after reset.
  - FETCH: imem_req_o=1, imem_addr_o=PC_o. On the edge where imem_ack_i=1, Instr_o<=imem_rdata_i, instr_valid_o<=1, next state EXEC. With no ack, remain in FETCH; there is no timeout.
  - EXEC: imem_req_o=0 and instr_valid_o=1. Instr_o and PC_o are held stable. With done_i=0, remain in EXEC.
  - EXEC with done_i=1:
    - Next PC is PCTarget_i if PCSrc_i=1, else PCPlus4_o.
    - retire_cnt_o increments, wrapping modulo 2^RETIRE_W.
    - instr_valid_o<=0.
    - If PCSrc_i=1 and PCTarget_i[1:0]!=0: misalign_o<=1, PC_o is NOT updated, next state HALT.
    - Otherwise PC_o<=next PC and the next state is FETCH.
  - HALT: terminal until reset. imem_req_o=0, instr_valid_o=0, all other state held.
- Minimum latency is 2 cycles per instruction: ack in the first FETCH cycle, then done_i in the first EXEC cycle.
- Arithmetic: PCPlus4_o = PC_o + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000 and does not set misalign_o.
- imem_ack_i outside FETCH is ignored. done_i outside EXEC is ignored.
- op_o, funct3_o and funct7b5_o are purely combinational slices of Instr_o.

Decomposition:
- Add a fetch-state enum (IDLE, FETCH, EXEC, HALT) and a NOP_INSTR constant to ucsbece154a_defines.svh, alongside the existing opcode and funct3 constants.
- One natural combinational sub-module, ucsbece154a_pc_next: takes PC, PCSrc and PCTarget and produces PCPlus4, next PC and the misalign flag.
- The FSM, PC register, instruction register and retire counter stay in the top module.

Test Plan:
1. Reset, then ack on the first FETCH cycle with rdata=32'h0000_0513 -> cycle 2 shows imem_req_o=1 with addr 32'h0001_0000; cycle 3 shows instr_valid_o=1, op_o=7'h13, PCPlus4_o=32'h0001_0004.
2. Sequential flow: three instructions with PCSrc_i=0 and immediate ack/done -> PC_o steps 0x10000, 0x10004, 0x10008 and retire_cnt_o=3.
3. Taken branch: EXEC with PCSrc_i=1, PCTarget_i=32'h0001_0040, done_i=1 -> next imem_addr_o=32'h0001_0040.
4. Memory stall: ack withheld for 5 cycles -> imem_req_o stays 1, instr_valid_o stays 0 and PC_o is unchanged. Also drive a stray ack during EXEC -> Instr_o is unchanged.
5. Misaligned target 32'h0001_0042 taken -> misalign_o=1, state HALT, PC_o stays at the old value, imem_req_o=0 for all later cycles until reset.
6. Reset asserted mid-FETCH and mid-EXEC -> next cycle PC_o=TEXT_BASE, instr_valid_o=0 and retire_cnt_o=0. Also check wrap: PC_o=32'hFFFF_FFFC with PCSrc_i=0 -> PC_o becomes 0.
